// File: rtl/if_stage.sv
// if_stage: instruction fetch with prefetch FIFO; IF_STALL_CNT_EN adds a backpressure counter.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_data_i,
    input  logic        flush_i,
    input  logic [31:0] flush_addr_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_inst_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] stall_cnt_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0] cnt_q, cnt_d;
    logic [63:0] mem_q [DEPTH];
    logic run, full, push, pop;
    assign run        = state_q == RUN;
    assign full       = cnt_q == FULL;
    assign rom_ce_o   = run;
    assign rom_addr_o = run ? pc_q : '0;
    assign id_valid_o = cnt_q != '0;
    assign id_inst_o  = id_valid_o ? mem_q[rd_q][31:0] : '0;
    assign id_pc_o    = id_valid_o ? mem_q[rd_q][63:32] : '0;
    assign pop        = id_valid_o & id_ready_i;
    assign push       = run & ~flush_i & (~full | pop);
    // A flush wins over everything: the FIFO empties and the PC is redirected.
    always_comb begin
        state_d = RUN;
        pc_d    = flush_i ? {flush_addr_i[31:2], 2'b00} : push ? pc_q + 32'd4 : pc_q;
        wr_d    = flush_i ? '0 : push ? wr_q + PW'(1) : wr_q;
        rd_d    = flush_i ? '0 : pop ? rd_q + PW'(1) : rd_q;
        cnt_d   = flush_i ? '0 : cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= {RESET_PC[31:2], 2'b00};
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end
    // Entry storage needs no reset; the count gates visibility of stale words.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {pc_q, rom_data_i};
    end
`ifdef IF_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;
    always_comb begin
        stall_d = (id_valid_o & ~id_ready_i & ~&stall_q) ? stall_q + 32'd1 : stall_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_q <= '0;
        else      stall_q <= stall_d;
    end
    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed vector table plus reset/wrap sequences for if_stage.
module tb_if_stage;
    localparam logic [31:0] K = 32'hDEAD_0000;
    logic clk = 1'b0;
    logic rst;
    logic ce, v, rdy, fl;
    logic [31:0] addr, fa, inst, pc, stall;
    logic ce1, v1, rdy1, fl1;
    logic [31:0] addr1, inst1, pc1, stall1, fa1;
    int pass = 0;
    int tot = 0;
    typedef struct {
        logic        rdy;
        logic        fl;
        logic [31:0] fa;
        logic        ce;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
    } vec_t;
    vec_t vt [14];
    always #5 clk = ~clk;
    if_stage #(.DEPTH(2)) u0 (
        .clk(clk), .rst(rst), .rom_ce_o(ce), .rom_addr_o(addr), .rom_data_i(addr ^ K),
        .flush_i(fl), .flush_addr_i(fa), .id_valid_o(v), .id_ready_i(rdy),
        .id_inst_o(inst), .id_pc_o(pc), .stall_cnt_o(stall)
    );
    if_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u1 (
        .clk(clk), .rst(rst), .rom_ce_o(ce1), .rom_addr_o(addr1), .rom_data_i(addr1 ^ K),
        .flush_i(fl1), .flush_addr_i(fa1), .id_valid_o(v1), .id_ready_i(rdy1),
        .id_inst_o(inst1), .id_pc_o(pc1), .stall_cnt_o(stall1)
    );
    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        tot++;
        if (a !== e) $display("FAIL %s: got %h expected %h", n, a, e);
        else pass++;
    endtask
    task automatic check_zero(input string n);
        check({n, " ce"}, 32'(ce), 32'd0);
        check({n, " addr"}, addr, 32'd0);
        check({n, " valid"}, 32'(v), 32'd0);
        check({n, " inst"}, inst, 32'd0);
        check({n, " pc"}, pc, 32'd0);
        check({n, " stall"}, stall, 32'd0);
    endtask
    initial begin
        logic [31:0] exp_stall;
`ifdef IF_STALL_CNT_EN
        exp_stall = 32'd5;
`else
        exp_stall = 32'd0;
`endif
        vt[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0};
        vt[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0};
        vt[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0};
        vt[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h0};
        vt[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h0};
        vt[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h0};
        vt[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h4};
        vt[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h8};
        vt[8]  = '{1'b0, 1'b1, 32'h103, 1'b1, 32'h10,  1'b1, 32'h8};
        vt[9]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0};
        vt[10] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100};
        vt[11] = '{1'b1, 1'b1, 32'h20,  1'b1, 32'h108, 1'b1, 32'h104};
        vt[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h20,  1'b0, 32'h0};
        vt[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h24,  1'b1, 32'h20};
        rdy = 1'b0; fl = 1'b0; fa = '0;
        rdy1 = 1'b1; fl1 = 1'b0; fa1 = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(negedge clk);
        check_zero("reset held");
        rst = 1'b1;
        for (int i = 0; i < 14; i++) begin
            rdy = vt[i].rdy; fl = vt[i].fl; fa = vt[i].fa;
            check($sformatf("c%0d ce", i), 32'(ce), 32'(vt[i].ce));
            check($sformatf("c%0d addr", i), addr, vt[i].addr);
            check($sformatf("c%0d valid", i), 32'(v), 32'(vt[i].v));
            check($sformatf("c%0d pc", i), pc, vt[i].pc);
            check($sformatf("c%0d inst", i), inst, vt[i].v ? vt[i].pc ^ K : 32'd0);
            if (i == 13) check("stall count", stall, exp_stall);
            @(negedge clk);
        end
        rdy = 1'b0; fl = 1'b0;
        check("pre-reset valid", 32'(v), 32'd1);
        check("pre-reset pc", pc, 32'h20);
        check("pre-reset addr", addr, 32'h28);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_zero("async reset");
        @(negedge clk);
        rdy = 1'b1;
        rst = 1'b1;
        check("restart c0 ce", 32'(ce), 32'd0);
        @(negedge clk);
        check("restart c1 ce", 32'(ce), 32'd1);
        check("restart c1 addr", addr, 32'h0);
        check("restart c1 valid", 32'(v), 32'd0);
        check("wrap c1 addr", addr1, 32'hFFFF_FFF8);
        @(negedge clk);
        check("restart c2 addr", addr, 32'h4);
        check("restart c2 pc", pc, 32'h0);
        check("restart c2 inst", inst, K);
        check("wrap c2 pc", pc1, 32'hFFFF_FFF8);
        @(negedge clk);
        check("restart c3 addr", addr, 32'h8);
        check("restart c3 pc", pc, 32'h4);
        check("wrap c3 pc", pc1, 32'hFFFF_FFFC);
        check("wrap c3 addr", addr1, 32'h0);
        @(negedge clk);
        check("wrap c4 pc", pc1, 32'h0);
        check("wrap c4 inst", inst1, K);
        check("wrap stall", stall1, 32'd0);
        $display("%0d/%0d checks passed", pass, tot);
        $finish;
    end
endmodule
